// File: rtl/ctrl_resolve_unit_pkg.sv
// Shared types, flag positions, FSM encoding and the active-list age compare used by the
// control-resolve slice (ctrl_resolve_unit and ctrl_upd_fifo).
package ctrl_resolve_unit_pkg;

    localparam int unsigned FLAG_CTRL    = 5;
    localparam int unsigned FLAG_MISPRED = 0;

    // Storage width of PC fields in a queued predictor update; the top level narrows on read.
    localparam int unsigned UPD_PC_W = 32;

    typedef struct packed {
        logic [UPD_PC_W-1:0] pc;
        logic [UPD_PC_W-1:0] target;
        logic                dir;
    } upd_entry_t;

    typedef enum logic [1:0] {
        StIdle,
        StRedirect,
        StFlush
    } rec_state_e;

    // True when tag a is strictly older than tag b; the wrap bit flips the index order.
    function automatic logic older(input logic        a_wrap,
                                   input logic [31:0] a_idx,
                                   input logic        b_wrap,
                                   input logic [31:0] b_idx);
        logic res;
        if (a_wrap == b_wrap) begin
            res = (a_idx < b_idx);
        end else begin
            res = (a_idx > b_idx);
        end
        return res;
    endfunction

endpackage

// File: rtl/ctrl_upd_fifo.sv
// Synchronous FIFO for predictor updates. Pushes into a full queue are dropped unless a pop
// happens in the same cycle; when empty, the head output holds the last popped entry.
module ctrl_upd_fifo
    import ctrl_resolve_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push_i,
    input  upd_entry_t push_data_i,
    input  logic       pop_i,
    output logic       valid_o,
    output upd_entry_t head_o,
    output logic       full_o,
    output logic       empty_o,
    output logic       drop_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    upd_entry_t       mem_q [DEPTH];
    upd_entry_t       last_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == DEPTH_CNT);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign drop_o  = push_i & full_o & ~do_pop;
    assign valid_o = ~empty_o;
    assign head_o  = empty_o ? last_q : mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            last_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Power-of-two depth: pointers wrap by natural overflow.
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                last_q   <= mem_q[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ctrl_resolve_unit.sv
// Resolves control-ALU results: drives fetch redirect and flush on the oldest mispredict and
// queues predictor updates. Define CTRL_RESOLVE_STATS_EN to add saturating event counters.
module ctrl_resolve_unit
    import ctrl_resolve_unit_pkg::*;
#(
    parameter int unsigned SIZE_PC        = 32,
    parameter int unsigned SIZE_AL_LOG    = 7,
    parameter int unsigned UPD_FIFO_DEPTH = 4,
    parameter int unsigned FLUSH_CYCLES   = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 exeValid_i,
    input  logic [SIZE_PC-1:0]   exePC_i,
    input  logic [SIZE_PC-1:0]   exeNextPC_i,
    input  logic                 exeDirection_i,
    input  logic [7:0]           exeFlags_i,
    input  logic [SIZE_AL_LOG:0] exeAlId_i,
    output logic                 redirectValid_o,
    output logic [SIZE_PC-1:0]   redirectPC_o,
    output logic                 flush_o,
    output logic [SIZE_AL_LOG:0] flushAlId_o,
    output logic                 bpUpdValid_o,
    output logic [SIZE_PC-1:0]   bpUpdPC_o,
    output logic [SIZE_PC-1:0]   bpUpdTarget_o,
    output logic                 bpUpdDir_o,
    input  logic                 bpUpdReady_i
`ifdef CTRL_RESOLVE_STATS_EN
    ,
    output logic [31:0]          mispredCnt_o,
    output logic [31:0]          updDropCnt_o
`endif
);

    localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(FLUSH_CYCLES - 1);

    rec_state_e           state_q;
    logic [CNT_W-1:0]     flush_cnt_q;
    logic                 redirect_valid_q;
    logic [SIZE_PC-1:0]   redirect_pc_q;
    logic                 flush_q;
    logic [SIZE_AL_LOG:0] flush_al_id_q;

    logic       recovering;
    logic       exe_older;
    logic       accept;
    logic       rec_start;
    upd_entry_t push_entry;
    upd_entry_t head;
    logic       upd_full;
    logic       upd_empty;
    logic       upd_drop;
    logic       unused_flags;

    assign unused_flags = ^{exeFlags_i[7:6], exeFlags_i[4:1]};

    // While recovering, only results strictly older than the current flush tag survive.
    assign recovering = (state_q != StIdle);
    assign exe_older  = older(exeAlId_i[SIZE_AL_LOG], 32'(exeAlId_i[SIZE_AL_LOG-1:0]),
                              flush_al_id_q[SIZE_AL_LOG], 32'(flush_al_id_q[SIZE_AL_LOG-1:0]));
    assign accept     = exeValid_i & exeFlags_i[FLAG_CTRL] & ~(recovering & ~exe_older);
    assign rec_start  = accept & exeFlags_i[FLAG_MISPRED];

    always_comb begin
        push_entry        = '0;
        push_entry.pc     = UPD_PC_W'(exePC_i);
        push_entry.target = UPD_PC_W'(exeNextPC_i);
        push_entry.dir    = exeDirection_i;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= StIdle;
            flush_cnt_q      <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            flush_q          <= 1'b0;
            flush_al_id_q    <= '0;
        end else begin
            redirect_valid_q <= 1'b0;
            if (rec_start) begin
                // Also covers a restart from an older mispredict mid-recovery.
                state_q          <= StRedirect;
                redirect_valid_q <= 1'b1;
                redirect_pc_q    <= exeNextPC_i;
                flush_q          <= 1'b1;
                flush_al_id_q    <= exeAlId_i;
                flush_cnt_q      <= FLUSH_RELOAD;
            end else begin
                case (state_q)
                    StIdle: begin
                        state_q <= StIdle;
                    end
                    StRedirect, StFlush: begin
                        if (flush_cnt_q == '0) begin
                            state_q <= StIdle;
                            flush_q <= 1'b0;
                        end else begin
                            state_q     <= StFlush;
                            flush_cnt_q <= flush_cnt_q - 1'b1;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        flush_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign redirectValid_o = redirect_valid_q;
    assign redirectPC_o    = redirect_pc_q;
    assign flush_o         = flush_q;
    assign flushAlId_o     = flush_al_id_q;

    ctrl_upd_fifo #(
        .DEPTH (UPD_FIFO_DEPTH)
    ) u_upd_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (accept),
        .push_data_i (push_entry),
        .pop_i       (bpUpdReady_i),
        .valid_o     (bpUpdValid_o),
        .head_o      (head),
        .full_o      (upd_full),
        .empty_o     (upd_empty),
        .drop_o      (upd_drop)
    );

    assign bpUpdPC_o     = head.pc[SIZE_PC-1:0];
    assign bpUpdTarget_o = head.target[SIZE_PC-1:0];
    assign bpUpdDir_o    = head.dir;

`ifdef CTRL_RESOLVE_STATS_EN
    logic [31:0] mispred_cnt_q;
    logic [31:0] upd_drop_cnt_q;
    logic        unused_fifo;

    assign unused_fifo = upd_full ^ upd_empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mispred_cnt_q  <= '0;
            upd_drop_cnt_q <= '0;
        end else begin
            if (rec_start && (mispred_cnt_q != '1)) begin
                mispred_cnt_q <= mispred_cnt_q + 1'b1;
            end
            if (upd_drop && (upd_drop_cnt_q != '1)) begin
                upd_drop_cnt_q <= upd_drop_cnt_q + 1'b1;
            end
        end
    end

    assign mispredCnt_o = mispred_cnt_q;
    assign updDropCnt_o = upd_drop_cnt_q;
`else
    logic unused_fifo;

    assign unused_fifo = upd_full ^ upd_empty ^ upd_drop;
`endif

endmodule

// File: tb/tb_ctrl_resolve_unit.sv
// Self-checking bench for ctrl_resolve_unit: directed scenarios plus a randomized run against
// a queue-based reference model. Counter checks apply when CTRL_RESOLVE_STATS_EN is defined.
module tb_ctrl_resolve_unit;

    localparam int DEPTH = 4;
    localparam int FLUSH = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        dir;
    } ent_t;

    logic        clk            = 1'b0;
    logic        reset_n        = 1'b0;
    logic        exeValid_i     = 1'b0;
    logic [31:0] exePC_i        = '0;
    logic [31:0] exeNextPC_i    = '0;
    logic        exeDirection_i = 1'b0;
    logic [7:0]  exeFlags_i     = '0;
    logic [7:0]  exeAlId_i      = '0;
    logic        bpUpdReady_i   = 1'b0;
    logic        redirectValid_o;
    logic [31:0] redirectPC_o;
    logic        flush_o;
    logic [7:0]  flushAlId_o;
    logic        bpUpdValid_o;
    logic [31:0] bpUpdPC_o;
    logic [31:0] bpUpdTarget_o;
    logic        bpUpdDir_o;
`ifdef CTRL_RESOLVE_STATS_EN
    logic [31:0] mispredCnt_o;
    logic [31:0] updDropCnt_o;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model state
    ent_t        m_q[$];
    ent_t        m_last;
    logic        m_redir;
    logic [31:0] m_tgt;
    logic [7:0]  m_tag;
    int          m_flush_left;
    int unsigned m_mis;
    int unsigned m_drops;
    logic [31:0] popped[$];

    always #5 clk = ~clk;

    ctrl_resolve_unit #(
        .SIZE_PC        (32),
        .SIZE_AL_LOG    (7),
        .UPD_FIFO_DEPTH (DEPTH),
        .FLUSH_CYCLES   (FLUSH)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .exeValid_i      (exeValid_i),
        .exePC_i         (exePC_i),
        .exeNextPC_i     (exeNextPC_i),
        .exeDirection_i  (exeDirection_i),
        .exeFlags_i      (exeFlags_i),
        .exeAlId_i       (exeAlId_i),
        .redirectValid_o (redirectValid_o),
        .redirectPC_o    (redirectPC_o),
        .flush_o         (flush_o),
        .flushAlId_o     (flushAlId_o),
        .bpUpdValid_o    (bpUpdValid_o),
        .bpUpdPC_o       (bpUpdPC_o),
        .bpUpdTarget_o   (bpUpdTarget_o),
        .bpUpdDir_o      (bpUpdDir_o),
        .bpUpdReady_i    (bpUpdReady_i)
`ifdef CTRL_RESOLVE_STATS_EN
        ,
        .mispredCnt_o    (mispredCnt_o),
        .updDropCnt_o    (updDropCnt_o)
`endif
    );

    // a is older than b when b lies 1..127 steps ahead of a on the 256-entry tag circle.
    function automatic bit m_older(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] d;
        d = b - a;
        return (d >= 8'd1) && (d <= 8'd127);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_last       = '0;
        m_redir      = 1'b0;
        m_tgt        = '0;
        m_tag        = '0;
        m_flush_left = 0;
        m_mis        = 0;
        m_drops      = 0;
    endtask

    // Drive one cycle of inputs, advance the model across the edge, return at posedge+1.
    task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] npc,
                         input logic dir, input logic [7:0] fl, input logic [7:0] tag,
                         input logic rdy);
        bit acc;
        bit pop;
        exeValid_i     = v;
        exePC_i        = pc;
        exeNextPC_i    = npc;
        exeDirection_i = dir;
        exeFlags_i     = fl;
        exeAlId_i      = tag;
        bpUpdReady_i   = rdy;
        acc = v && fl[5] && !((m_flush_left > 0) && !m_older(tag, m_tag));
        pop = (m_q.size() != 0) && rdy;
        @(posedge clk);
        if (pop) m_last = m_q.pop_front();
        if (acc) begin
            if (m_q.size() < DEPTH) m_q.push_back('{pc: pc, tgt: npc, dir: dir});
            else m_drops++;
        end
        if (acc && fl[0]) begin
            m_redir      = 1'b1;
            m_tgt        = npc;
            m_tag        = tag;
            m_flush_left = FLUSH;
            m_mis++;
        end else begin
            m_redir = 1'b0;
            if (m_flush_left > 0) m_flush_left--;
        end
        #1;
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 8'h00, 8'h00, rdy);
    endtask

    task automatic drain();
        popped.delete();
        for (int i = 0; i < 2 * DEPTH; i++) begin
            if (bpUpdValid_o) popped.push_back(bpUpdPC_o);
            idle(1'b1);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({redirectValid_o, flush_o, bpUpdValid_o, bpUpdDir_o} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b exp=0000",
                     {redirectValid_o, flush_o, bpUpdValid_o, bpUpdDir_o});
        end
        checks++;
        if ({redirectPC_o, flushAlId_o, bpUpdPC_o, bpUpdTarget_o} !== '0) begin
            errors++;
            $display("FAIL reset_data got=%h/%h/%h/%h exp=0", redirectPC_o, flushAlId_o,
                     bpUpdPC_o, bpUpdTarget_o);
        end
        @(negedge clk);
        reset_n = 1'b1;
        idle(1'b0);
    endtask

    task automatic test_mispredict();
        cycle(1'b1, 32'h400, 32'h40C, 1'b1, 8'h21, 8'd5, 1'b0);
        checks++;
        if (redirectValid_o !== 1'b1 || redirectPC_o !== 32'h40C) begin
            errors++;
            $display("FAIL t1_redirect got=%b/%h exp=1/40c", redirectValid_o, redirectPC_o);
        end
        checks++;
        if (flush_o !== 1'b1 || flushAlId_o !== 8'd5) begin
            errors++;
            $display("FAIL t1_flush got=%b/%0d exp=1/5", flush_o, flushAlId_o);
        end
        checks++;
        if ({bpUpdValid_o, bpUpdPC_o, bpUpdTarget_o, bpUpdDir_o} !== {1'b1, 32'h400, 32'h40C, 1'b1}) begin
            errors++;
            $display("FAIL t1_queue_head got=%b/%h/%h/%b exp=1/400/40c/1", bpUpdValid_o,
                     bpUpdPC_o, bpUpdTarget_o, bpUpdDir_o);
        end
        idle(1'b0);
        checks++;
        if (redirectValid_o !== 1'b0 || flush_o !== 1'b1 || flushAlId_o !== 8'd5) begin
            errors++;
            $display("FAIL t1_flush2 got=%b/%b/%0d exp=0/1/5", redirectValid_o, flush_o,
                     flushAlId_o);
        end
        idle(1'b0);
        checks++;
        if (flush_o !== 1'b0) begin
            errors++;
            $display("FAIL t1_flush_end got=%b exp=0", flush_o);
        end
        drain();
        checks++;
        if (popped.size() != 1 || bpUpdValid_o !== 1'b0 || bpUpdPC_o !== 32'h400) begin
            errors++;
            $display("FAIL t1_drain got=%0d/%b/%h exp=1/0/400", popped.size(), bpUpdValid_o,
                     bpUpdPC_o);
        end
    endtask

    task automatic test_restart();
        cycle(1'b1, 32'h1000, 32'h1100, 1'b0, 8'h21, 8'd10, 1'b0);
        cycle(1'b1, 32'h2000, 32'h2200, 1'b1, 8'h21, 8'd3, 1'b0);
        checks++;
        if (redirectValid_o !== 1'b1 || redirectPC_o !== 32'h2200 || flushAlId_o !== 8'd3) begin
            errors++;
            $display("FAIL t2_restart got=%b/%h/%0d exp=1/2200/3", redirectValid_o,
                     redirectPC_o, flushAlId_o);
        end
        cycle(1'b1, 32'h3000, 32'h3300, 1'b1, 8'hE1, 8'd12, 1'b0);
        checks++;
        if (redirectValid_o !== 1'b0 || flush_o !== 1'b1 || flushAlId_o !== 8'd3) begin
            errors++;
            $display("FAIL t2_younger got=%b/%b/%0d exp=0/1/3", redirectValid_o, flush_o,
                     flushAlId_o);
        end
        idle(1'b0);
        checks++;
        if (flush_o !== 1'b0) begin
            errors++;
            $display("FAIL t2_flush_len got=%b exp=0", flush_o);
        end
        drain();
        checks++;
        if (popped.size() != 2) begin
            errors++;
            $display("FAIL t2_push_count got=%0d exp=2", popped.size());
        end
    endtask

    task automatic test_wrap();
        cycle(1'b1, 32'h5000, 32'h5004, 1'b0, 8'h21, 8'h82, 1'b0);
        cycle(1'b1, 32'h5100, 32'h5104, 1'b0, 8'h21, 8'h01, 1'b0);
        checks++;
        if (redirectValid_o !== 1'b0 || flushAlId_o !== 8'h82) begin
            errors++;
            $display("FAIL t3_not_older got=%b/%h exp=0/82", redirectValid_o, flushAlId_o);
        end
        cycle(1'b1, 32'h5200, 32'h5204, 1'b1, 8'h21, 8'd120, 1'b0);
        checks++;
        if (redirectValid_o !== 1'b1 || redirectPC_o !== 32'h5204 || flushAlId_o !== 8'd120) begin
            errors++;
            $display("FAIL t3_wrap_restart got=%b/%h/%0d exp=1/5204/120", redirectValid_o,
                     redirectPC_o, flushAlId_o);
        end
        idle(1'b0);
        idle(1'b0);
        drain();
        checks++;
        if (popped.size() != 2) begin
            errors++;
            $display("FAIL t3_push_count got=%0d exp=2", popped.size());
        end
    endtask

    task automatic test_full_drop();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 32'h100 + 32'(4 * i), 32'h900 + 32'(i), 1'b0, 8'h20, 8'(20 + i), 1'b0);
        end
`ifdef CTRL_RESOLVE_STATS_EN
        checks++;
        if (updDropCnt_o !== 32'd1) begin
            errors++;
            $display("FAIL t4_drop_cnt got=%0d exp=1", updDropCnt_o);
        end
`endif
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bpUpdValid_o !== 1'b1 || bpUpdPC_o !== 32'h100 + 32'(4 * i)) begin
                errors++;
                $display("FAIL t4_pop%0d got=%b/%h exp=1/%h", i, bpUpdValid_o, bpUpdPC_o,
                         32'h100 + 32'(4 * i));
            end
            idle(1'b1);
        end
        checks++;
        if (bpUpdValid_o !== 1'b0 || bpUpdPC_o !== 32'h10C) begin
            errors++;
            $display("FAIL t4_empty got=%b/%h exp=0/10c", bpUpdValid_o, bpUpdPC_o);
        end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 32'h600 + 32'(4 * i), 32'h0, 1'b1, 8'h20, 8'(30 + i), 1'b0);
        end
        cycle(1'b1, 32'h700, 32'h0, 1'b1, 8'h20, 8'd40, 1'b1);
        drain();
        checks++;
        if (popped.size() != 4 || popped[0] !== 32'h604 || popped[3] !== 32'h700) begin
            errors++;
            $display("FAIL t5_push_pop got=%0d entries first=%h last=%h exp=4/604/700",
                     popped.size(), (popped.size() > 0) ? popped[0] : 32'hx,
                     (popped.size() > 0) ? popped[popped.size() - 1] : 32'hx);
        end
    endtask

    task automatic test_reset_mid_flush();
        cycle(1'b1, 32'h800, 32'h880, 1'b1, 8'h21, 8'd50, 1'b0);
        cycle(1'b1, 32'h804, 32'h0, 1'b0, 8'h20, 8'd49, 1'b0);
        checks++;
        if (flush_o !== 1'b1) begin
            errors++;
            $display("FAIL t6_in_flush got=%b exp=1", flush_o);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({redirectValid_o, flush_o, bpUpdValid_o} !== 3'b0 || flushAlId_o !== 8'd0) begin
            errors++;
            $display("FAIL t6_async_reset got=%b/%h exp=000/0",
                     {redirectValid_o, flush_o, bpUpdValid_o}, flushAlId_o);
        end
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            checks++;
            if ({redirectValid_o, flush_o, bpUpdValid_o} !== 3'b0) begin
                errors++;
                $display("FAIL t6_after_release%0d got=%b exp=000", i,
                         {redirectValid_o, flush_o, bpUpdValid_o});
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] fl;
        ent_t       exp_head;
        for (int n = 0; n < 600; n++) begin
            fl    = 8'($urandom);
            fl[5] = ($urandom_range(0, 9) < 8);
            fl[0] = ($urandom_range(0, 3) == 0);
            cycle(($urandom_range(0, 9) < 6), $urandom, $urandom, 1'($urandom), fl,
                  8'($urandom), ($urandom_range(0, 9) < 4));
            checks++;
            if (redirectValid_o !== m_redir || (m_redir && redirectPC_o !== m_tgt)) begin
                errors++;
                $display("FAIL rnd_redirect cyc=%0d got=%b/%h exp=%b/%h", n, redirectValid_o,
                         redirectPC_o, m_redir, m_tgt);
            end
            checks++;
            if (flush_o !== (m_flush_left > 0) || (flush_o && flushAlId_o !== m_tag)) begin
                errors++;
                $display("FAIL rnd_flush cyc=%0d got=%b/%h exp=%b/%h", n, flush_o,
                         flushAlId_o, (m_flush_left > 0), m_tag);
            end
            exp_head = (m_q.size() != 0) ? m_q[0] : m_last;
            checks++;
            if (bpUpdValid_o !== (m_q.size() != 0) ||
                {bpUpdPC_o, bpUpdTarget_o, bpUpdDir_o} !== exp_head) begin
                errors++;
                $display("FAIL rnd_queue cyc=%0d got=%b/%h/%h/%b exp=%b/%h/%h/%b", n,
                         bpUpdValid_o, bpUpdPC_o, bpUpdTarget_o, bpUpdDir_o,
                         (m_q.size() != 0), exp_head.pc, exp_head.tgt, exp_head.dir);
            end
        end
`ifdef CTRL_RESOLVE_STATS_EN
        checks++;
        if (mispredCnt_o !== m_mis || updDropCnt_o !== m_drops) begin
            errors++;
            $display("FAIL rnd_counters got=%0d/%0d exp=%0d/%0d", mispredCnt_o, updDropCnt_o,
                     m_mis, m_drops);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_mispredict();
        test_restart();
        test_wrap();
        test_full_drop();
        test_full_push_pop();
        test_reset_mid_flush();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
